note_draw_scheduler: RTL

Sequencer that owns the VGA plotter port for the scrolling note squares. It holds up to NUM_NOTES note slots and, on each 60 Hz animation tick, walks every active slot through erase, move and draw. Erase blacks out the old square, move shifts it left, and draw paints the new position. It sits between the 1/60 s rate divider output and the VGA adapter's x/y/colour/plot inputs, and accepts spawn requests from the song sequencer.

---
 rtl/note_draw_pkg.sv | 35 +++
 rtl/square_pixel_walker.sv | 53 +++++
 rtl/note_draw_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/note_draw_pkg.sv
// Shared types and constants for the note-square draw scheduler.
// The state enum always lists CLEAR; that state is only reachable when the
// block is built with NOTE_DRAW_CLEAR_EN defined.
package note_draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    ERASE,
    MOVE,
    DRAW,
    NEXT,
    CLEAR
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Coordinate and colour widths of the VGA adapter port.
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam logic [C_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [C_W-1:0] COLOUR_RED   = 3'b100;

  // One note square as held in a slot.
  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } slot_t;

endpackage

// File: rtl/square_pixel_walker.sv
// Walks a W x H rectangle row-major, one pixel per cycle (px fastest).
// A start pulse begins a walk from (0,0). busy is high for exactly W*H
// cycles, px/py hold the current pixel, and done marks the last pixel.
module square_pixel_walker
  import note_draw_pkg::*;
#(
  parameter int W = 4,
  parameter int H = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py
);

  logic last_col;
  logic last_row;

  assign last_col = (px == X_W'(W - 1));
  assign last_row = (py == Y_W'(H - 1));
  assign done     = busy && last_col && last_row;

  // Pixel counters: restart on start, step while busy, park at (0,0) when done.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      busy <= 1'b0;
      px   <= '0;
      py   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      px   <= '0;
      py   <= '0;
    end else if (busy) begin
      if (last_col) begin
        px <= '0;
        if (last_row) begin
          py   <= '0;
          busy <= 1'b0;
        end else begin
          py <= py + 1'b1;
        end
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_draw_scheduler.sv
// Owns the VGA plotter port for the scrolling note squares. On every
// animation tick each active slot is erased, shifted left by STEP and
// redrawn; a square that runs off the left edge is dropped with a miss pulse.
// Optional build macro NOTE_DRAW_CLEAR_EN: after reset the whole screen is
// swept black (CLEAR state) before the scheduler becomes idle.
module note_draw_scheduler
  import note_draw_pkg::*;
#(
  parameter int NUM_NOTES   = 4,
  parameter int SQUARE_SIZE = 4,
  parameter int STEP        = 1,
  parameter int X_START     = 156
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           spawn,
  input  logic [Y_W-1:0] spawn_y,
  input  logic [C_W-1:0] spawn_colour,
  output logic           spawn_ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           miss,
  output logic           frame_overrun
);

  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);
`ifdef NOTE_DRAW_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  slot_t            slots [NUM_NOTES];
  slot_t            cur;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             spawn_accept;
  logic             off_edge;

  logic             sq_start;
  logic             sq_busy;
  logic             sq_done;
  logic [X_W-1:0]   sq_px;
  logic [Y_W-1:0]   sq_py;

  logic             clr_busy;
  logic             clr_done;

  logic             pix_valid;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [C_W-1:0]   pix_colour;
  logic [X_W-1:0]   x_hold;
  logic [Y_W-1:0]   y_hold;
  logic [C_W-1:0]   colour_hold;

  assign cur          = slots[idx];
  assign off_edge     = (int'(cur.x) < STEP);
  assign spawn_ready  = (state == IDLE) && free_found;
  assign spawn_accept = spawn && spawn_ready;
  assign busy         = (state != IDLE);

  // Walk starts: erase on entering an active slot, draw after a surviving move.
  assign sq_start = ((state == SLOT) && cur.active) || ((state == MOVE) && !off_edge);

  square_pixel_walker #(
    .W (SQUARE_SIZE),
    .H (SQUARE_SIZE)
  ) u_square_walker (
    .clock (clock),
    .reset (reset),
    .start (sq_start),
    .busy  (sq_busy),
    .done  (sq_done),
    .px    (sq_px),
    .py    (sq_py)
  );

`ifdef NOTE_DRAW_CLEAR_EN
  logic           clr_start;
  logic [X_W-1:0] clr_px;
  logic [Y_W-1:0] clr_py;

  // The sweep starts in the first CLEAR cycle and never restarts once IDLE.
  assign clr_start = (state == CLEAR) && !clr_busy;

  square_pixel_walker #(
    .W (SCREEN_W),
    .H (SCREEN_H)
  ) u_clear_walker (
    .clock (clock),
    .reset (reset),
    .start (clr_start),
    .busy  (clr_busy),
    .done  (clr_done),
    .px    (clr_px),
    .py    (clr_py)
  );
`else
  // CLEAR is unreachable without the sweep; leave it at once if ever entered.
  assign clr_busy = 1'b0;
  assign clr_done = 1'b1;
`endif

  // Lowest-index free slot, for spawn placement and spawn_ready.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (!slots[i].active) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state logic for the per-slot erase/move/draw sequence.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (frame_tick) next_state = SLOT;
      SLOT:    next_state = cur.active ? ERASE : NEXT;
      ERASE:   if (sq_done) next_state = MOVE;
      MOVE:    next_state = off_edge ? NEXT : DRAW;
      DRAW:    if (sq_done) next_state = NEXT;
      NEXT:    next_state = (idx == LAST_IDX) ? IDLE : SLOT;
      CLEAR:   if (clr_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

  // Slot index: advances in NEXT, wraps to 0 so each pass starts at slot 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
    end else if (state == NEXT) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // Slot storage: spawn writes happen only in IDLE, moves only in MOVE.
  always_ff @(posedge clock) begin
    // NOTE: the slots are a handful of flops rather than a RAM, so reset
    // clears every one of them and no stale note survives a mid-pass reset.
    if (reset) begin
      for (int i = 0; i < NUM_NOTES; i++) slots[i] <= '0;
    end else begin
      if (spawn_accept) begin
        slots[free_idx] <= '{active: 1'b1, x: X_W'(X_START), y: spawn_y, colour: spawn_colour};
      end
      if (state == MOVE) begin
        if (off_edge) slots[idx].active <= 1'b0;
        else          slots[idx].x      <= cur.x - X_W'(STEP);
      end
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      miss          <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      miss          <= (state == MOVE) && off_edge;
      frame_overrun <= frame_tick && (state != IDLE);
    end
  end

  // Current pixel: square walker offset from the slot, or the screen sweep.
  always_comb begin
    pix_valid  = sq_busy || clr_busy;
    pix_x      = cur.x + sq_px;
    pix_y      = cur.y + sq_py;
    pix_colour = (state == DRAW) ? cur.colour : COLOUR_BLACK;
`ifdef NOTE_DRAW_CLEAR_EN
    if (clr_busy) begin
      pix_x      = clr_px;
      pix_y      = clr_py;
      pix_colour = COLOUR_BLACK;
    end
`endif
  end

  // Last plotted pixel, so x/y/colour hold steady while plot is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_hold      <= '0;
      y_hold      <= '0;
      colour_hold <= '0;
    end else if (pix_valid) begin
      x_hold      <= pix_x;
      y_hold      <= pix_y;
      colour_hold <= pix_colour;
    end
  end

  assign plot   = pix_valid;
  assign x      = pix_valid ? pix_x      : x_hold;
  assign y      = pix_valid ? pix_y      : y_hold;
  assign colour = pix_valid ? pix_colour : colour_hold;

endmodule
